seg_scan_decoder: RTL and testbench
===================================

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 SETTLE, default 4, number of consecutive clk cycles an anode selection must hold before its segments are sampled (legal range 1-255).
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 digit  input  [0:7]  active-low segment lines: digit[0]..digit[6] = segments a..g, digit[7] = decimal point; same clock domain, no synchronizer.
REQ-005 segment  input  [0:3]  active-low anode enables; segment[0] = leftmost digit, segment[3] = rightmost.
REQ-006 value  output  [15:0]  last complete decoded frame; segment[0] digit in value[15:12], segment[3] digit in value[3:0].
REQ-007 dp  output  [3:0]  decimal-point state per slot, 1 = lit; dp[3] = segment[0] slot, dp[0] = segment[3] slot.
REQ-008 blank  output  [3:0]  1 = slot was all-segments-off in last frame; same bit order as dp.
REQ-009 bad  output  [3:0]  1 = slot held an undecodable pattern in last frame; same bit order as dp.
REQ-010 valid  output  1  one-cycle pulse when value/dp/blank/bad update.

Function
REQ-011 Anode select legal only when exactly one segment bit is 0; zero or multiple low bits = idle, no capture.
REQ-012 Per-dwell FSM, two states: SCAN (counting) and HOLD (slot captured, waiting for anode change).
REQ-013 Stability counter: 1 on first cycle of a legal selection differing from previous cycle's selection; +1 each cycle the selection is unchanged; saturates at SETTLE.
REQ-014 In SCAN, the edge at which counter equals SETTLE samples digit into the selected slot and moves to HOLD.
REQ-015 In HOLD, no further sampling of that dwell; any change of segment (including idle) returns to SCAN with counter restarted.
REQ-016 Idle selection clears counter to 0 and forces SCAN.
REQ-017 Decode digit[0:6] (a..g, active-low) to a nibble: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
REQ-018 Pattern 1111111: nibble 0, blank bit 1, bad bit 0.
REQ-019 Any other pattern: nibble 0, bad bit 1, blank bit 0.
REQ-020 dp slot bit = ~digit[7] at sample edge, independent of decode result.
REQ-021 4-bit captured mask tracks slots sampled in the current frame; recapture of an already-marked slot before frame completion overwrites its staging entry (newest wins).
REQ-022 When the mask becomes 1111, the next edge copies all staging entries to value/dp/blank/bad, pulses valid for exactly that cycle, and clears the mask.
REQ-023 A capture on the same edge the mask clears counts toward the new frame.
REQ-024 Outputs hold between valid pulses; no partial-frame updates.
REQ-025 Minimum latency: SETTLE cycles of stable selection to capture, plus 1 cycle to valid after the fourth slot.

Reset
REQ-026 reset high asynchronously forces value=16'h0000, dp=0, blank=0, bad=0, valid=0, mask=0, counter=0, staging entries=0, FSM=SCAN.
REQ-027 Reset asserted mid-frame discards all partial captures; first frame after release requires four fresh captures.
REQ-028 First sampling possible SETTLE cycles after release, even if segment was already stable during reset.

Verification
REQ-029 SETTLE=4; scan segment 0111,1011,1101,1110 at 8 cycles each with patterns for 1,2,3,4, dp off -> one valid pulse, value=16'h1234, dp=0, blank=0, bad=0.
REQ-030 Same scan, each dwell only 3 cycles -> no capture, valid never asserts, outputs stay at reset values.
REQ-031 Frame showing A,b,C,d with digit[7]=0 on slot segment[1] -> value=16'hABCD, dp=4'b0100.
REQ-032 Slot segment[2] driven 1111111, slot segment[3] driven 1010101 -> blank=4'b0010, bad=4'b0001, value[7:0]=8'h00.
REQ-033 segment=0011 (two anodes low) for 20 cycles interleaved in a scan -> ignored; frame completes only after all four legal dwells.
REQ-034 reset pulsed after three slots captured, then full 5,6,7,8 scan -> exactly one valid, value=16'h5678.

Source files
------------

// File: rtl/seg_scan_decoder_if.sv
// Signal bundle between a multiplexed 4-digit 7-segment scan source and the decoder.
// The master drives the scanned segment/anode lines; the slave returns decoded frames.
interface seg_scan_decoder_if;
  logic [0:7]  digit;
  logic [0:3]  segment;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic [3:0]  bad;
  logic        valid;

  modport master (
    output digit, segment,
    input  value, dp, blank, bad, valid
  );

  modport slave (
    input  digit, segment,
    output value, dp, blank, bad, valid
  );
endinterface

// File: rtl/seg_scan_decoder.sv
// Recovers four hex digits from a multiplexed 7-segment display scan.
// Each anode dwell is sampled once after it has been stable; a full frame is published at once.
module seg_scan_decoder #(
  parameter int unsigned SETTLE = 4
) (
  input logic              clk,
  input logic              reset,
  seg_scan_decoder_if.slave bus
);

  localparam logic [7:0] SETTLE_C = 8'(SETTLE);

  typedef enum logic {SCAN, HOLD} state_t;

  state_t      state, state_next;
  logic [0:3]  prev_seg;
  logic [7:0]  cnt, cnt_cur;
  logic [3:0]  slot_oh;
  logic        legal, changed, capture;
  logic [3:0]  nib;
  logic        nib_blank, nib_bad;
  logic [3:0]  mask;
  logic [15:0] stage_val;
  logic [3:0]  stage_dp, stage_blank, stage_bad;
  logic [15:0] value_q;
  logic [3:0]  dp_q, blank_q, bad_q;
  logic        valid_q;

  // Slot one-hot uses output bit order: segment[0] maps to bit 3.
  always_comb begin
    slot_oh = 4'b0000;
    case (bus.segment)
      4'b0111: slot_oh = 4'b1000;
      4'b1011: slot_oh = 4'b0100;
      4'b1101: slot_oh = 4'b0010;
      4'b1110: slot_oh = 4'b0001;
      default: slot_oh = 4'b0000;
    endcase
  end

  assign legal   = (slot_oh != 4'b0000);
  assign changed = (bus.segment != prev_seg);

  always_comb begin
    cnt_cur = 8'd0;
    if (legal) begin
      if (changed)
        cnt_cur = 8'd1;
      else if (cnt < SETTLE_C)
        cnt_cur = cnt + 8'd1;
      else
        cnt_cur = cnt;
    end
  end

  // A changed anode restarts the dwell even from HOLD, so it may sample this very edge.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    if (!legal) begin
      state_next = SCAN;
    end else if ((state == SCAN || changed) && cnt_cur == SETTLE_C) begin
      capture    = 1'b1;
      state_next = HOLD;
    end else if (changed) begin
      state_next = SCAN;
    end
  end

  always_comb begin
    nib       = 4'h0;
    nib_blank = 1'b0;
    nib_bad   = 1'b0;
    case (bus.digit[0:6])
      7'b0000001: nib = 4'h0;
      7'b1001111: nib = 4'h1;
      7'b0010010: nib = 4'h2;
      7'b0000110: nib = 4'h3;
      7'b1001100: nib = 4'h4;
      7'b0100100: nib = 4'h5;
      7'b0100000: nib = 4'h6;
      7'b0001111: nib = 4'h7;
      7'b0000000: nib = 4'h8;
      7'b0000100: nib = 4'h9;
      7'b0001000: nib = 4'hA;
      7'b1100000: nib = 4'hB;
      7'b0110001: nib = 4'hC;
      7'b1000010: nib = 4'hD;
      7'b0110000: nib = 4'hE;
      7'b0111000: nib = 4'hF;
      7'b1111111: nib_blank = 1'b1;
      default:    nib_bad = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= SCAN;
    else
      state <= state_next;
  end

  // prev_seg resets to idle so a selection held through reset still counts as new.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_seg    <= 4'b1111;
      cnt         <= 8'd0;
      mask        <= 4'b0000;
      stage_val   <= 16'h0000;
      stage_dp    <= 4'b0000;
      stage_blank <= 4'b0000;
      stage_bad   <= 4'b0000;
      value_q     <= 16'h0000;
      dp_q        <= 4'b0000;
      blank_q     <= 4'b0000;
      bad_q       <= 4'b0000;
      valid_q     <= 1'b0;
    end else begin
      prev_seg <= bus.segment;
      cnt      <= cnt_cur;

      if (capture) begin
        for (int i = 0; i < 4; i++) begin
          if (slot_oh[i]) begin
            stage_val[4*i +: 4] <= nib;
            stage_dp[i]         <= ~bus.digit[7];
            stage_blank[i]      <= nib_blank;
            stage_bad[i]        <= nib_bad;
          end
        end
      end

      // Publish reads the old staging; a same-edge capture seeds the next frame.
      if (mask == 4'b1111) begin
        value_q <= stage_val;
        dp_q    <= stage_dp;
        blank_q <= stage_blank;
        bad_q   <= stage_bad;
        valid_q <= 1'b1;
        mask    <= capture ? slot_oh : 4'b0000;
      end else begin
        valid_q <= 1'b0;
        if (capture)
          mask <= mask | slot_oh;
      end
    end
  end

  assign bus.value = value_q;
  assign bus.dp    = dp_q;
  assign bus.blank = blank_q;
  assign bus.bad   = bad_q;
  assign bus.valid = valid_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: scans hand-built digit frames and checks published results.
// Expected values below are worked out by hand from the segment patterns driven.
module tb_seg_scan_decoder;

  localparam logic [6:0] P0 = 7'b0000001;
  localparam logic [6:0] P1 = 7'b1001111;
  localparam logic [6:0] P2 = 7'b0010010;
  localparam logic [6:0] P3 = 7'b0000110;
  localparam logic [6:0] P4 = 7'b1001100;
  localparam logic [6:0] P5 = 7'b0100100;
  localparam logic [6:0] P6 = 7'b0100000;
  localparam logic [6:0] P7 = 7'b0001111;
  localparam logic [6:0] P8 = 7'b0000000;
  localparam logic [6:0] P9 = 7'b0000100;
  localparam logic [6:0] PA = 7'b0001000;
  localparam logic [6:0] PB = 7'b1100000;
  localparam logic [6:0] PC = 7'b0110001;
  localparam logic [6:0] PD = 7'b1000010;
  localparam logic [6:0] PE = 7'b0110000;
  localparam logic [6:0] PF = 7'b0111000;
  localparam logic [6:0] PBLANK = 7'b1111111;
  localparam logic [6:0] PBAD   = 7'b1010101;

  logic clk = 1'b0;
  logic reset;
  int   total_count = 0;
  int   bad_count   = 0;
  int   valid_count = 0;
  int   base;

  seg_scan_decoder_if bus ();

  seg_scan_decoder #(.SETTLE(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.valid === 1'b1)
      valid_count++;
  end

  task automatic check_output(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total_count++;
    if (got !== exp) begin
      bad_count++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Holds one anode/pattern for exactly 'cycles' rising edges.
  task automatic apply_stimulus(input logic [0:3] seg, input logic [6:0] pat,
                                input logic dp_lit, input int cycles);
    @(negedge clk);
    bus.segment = seg;
    bus.digit   = {pat, ~dp_lit};
    repeat (cycles - 1) @(negedge clk);
  endtask

  task automatic scan_frame(input logic [6:0] d0, input logic [6:0] d1,
                            input logic [6:0] d2, input logic [6:0] d3,
                            input logic [3:0] dps, input int cycles);
    apply_stimulus(4'b0111, d0, dps[3], cycles);
    apply_stimulus(4'b1011, d1, dps[2], cycles);
    apply_stimulus(4'b1101, d2, dps[1], cycles);
    apply_stimulus(4'b1110, d3, dps[0], cycles);
  endtask

  initial begin
    bus.segment = 4'b1111;
    bus.digit   = 8'hFF;
    reset       = 1'b1;
    repeat (3) @(negedge clk);
    check_output("rst_value", bus.value, 16'h0000);
    check_output("rst_dp",    {12'h0, bus.dp},    16'h0000);
    check_output("rst_blank", {12'h0, bus.blank}, 16'h0000);
    check_output("rst_bad",   {12'h0, bus.bad},   16'h0000);
    check_output("rst_valid", {15'h0, bus.valid}, 16'h0000);
    reset = 1'b0;

    base = valid_count;
    scan_frame(P1, P2, P3, P4, 4'b0000, 3);
    apply_stimulus(4'b1111, PBLANK, 1'b0, 4);
    check_output("short_valid", 16'(valid_count - base), 16'd0);
    check_output("short_value", bus.value, 16'h0000);

    base = valid_count;
    scan_frame(P1, P2, P3, P4, 4'b0000, 8);
    apply_stimulus(4'b1111, PBLANK, 1'b0, 3);
    check_output("f1234_valid", 16'(valid_count - base), 16'd1);
    check_output("f1234_value", bus.value, 16'h1234);
    check_output("f1234_dp",    {12'h0, bus.dp},    16'h0000);
    check_output("f1234_blank", {12'h0, bus.blank}, 16'h0000);
    check_output("f1234_bad",   {12'h0, bus.bad},   16'h0000);

    base = valid_count;
    scan_frame(PA, PB, PC, PD, 4'b0100, 8);
    apply_stimulus(4'b1111, PBLANK, 1'b0, 3);
    check_output("abcd_valid", 16'(valid_count - base), 16'd1);
    check_output("abcd_value", bus.value, 16'hABCD);
    check_output("abcd_dp",    {12'h0, bus.dp}, 16'h0004);

    base = valid_count;
    scan_frame(P1, P2, PBLANK, PBAD, 4'b0000, 8);
    apply_stimulus(4'b1111, PBLANK, 1'b0, 3);
    check_output("bb_value", bus.value, 16'h1200);
    check_output("bb_blank", {12'h0, bus.blank}, 16'h0002);
    check_output("bb_bad",   {12'h0, bus.bad},   16'h0001);

    base = valid_count;
    apply_stimulus(4'b0111, P9, 1'b0, 8);
    apply_stimulus(4'b1011, P0, 1'b0, 8);
    apply_stimulus(4'b0011, P8, 1'b0, 20);
    check_output("dual_no_frame", 16'(valid_count - base), 16'd0);
    check_output("dual_hold_value", bus.value, 16'h1200);
    apply_stimulus(4'b1101, PE, 1'b0, 8);
    apply_stimulus(4'b1110, PF, 1'b0, 8);
    apply_stimulus(4'b1111, PBLANK, 1'b0, 3);
    check_output("dual_valid", 16'(valid_count - base), 16'd1);
    check_output("dual_value", bus.value, 16'h90EF);

    // Second dwell on slot 0 overwrites it; digit change while held must not resample.
    base = valid_count;
    apply_stimulus(4'b0111, P1, 1'b0, 8);
    apply_stimulus(4'b1111, PBLANK, 1'b0, 2);
    apply_stimulus(4'b0111, P7, 1'b0, 4);
    apply_stimulus(4'b0111, P9, 1'b0, 6);
    apply_stimulus(4'b1011, P2, 1'b0, 8);
    apply_stimulus(4'b1101, P3, 1'b0, 8);
    apply_stimulus(4'b1110, P4, 1'b0, 8);
    apply_stimulus(4'b1111, PBLANK, 1'b0, 3);
    check_output("newest_valid", 16'(valid_count - base), 16'd1);
    check_output("newest_value", bus.value, 16'h7234);

    apply_stimulus(4'b0111, P1, 1'b0, 8);
    apply_stimulus(4'b1011, P1, 1'b0, 8);
    apply_stimulus(4'b1101, P1, 1'b0, 8);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_output("midrst_value", bus.value, 16'h0000);
    reset = 1'b0;
    base = valid_count;
    scan_frame(P5, P6, P7, P8, 4'b0000, 8);
    apply_stimulus(4'b1111, PBLANK, 1'b0, 3);
    check_output("midrst_valid", 16'(valid_count - base), 16'd1);
    check_output("midrst_5678", bus.value, 16'h5678);

    $display("test done: total=%0d bad=%0d", total_count, bad_count);
    $finish;
  end

endmodule
